// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game controller.
package reaction_pkg;

    localparam int VALUE_W = 14;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps 16/14/13/11 expressed as bit positions 15/13/12/10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        GO,
        SHOW,
        ERR
    } state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            pulse     <= sync2_reg & ~prev_reg;
        end
    end

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game sequencer: random delay, stimulus lamp, ms-resolution
// reaction measurement, best-time tracking and display value generation.
module reaction_game_ctrl
    import reaction_pkg::*;
#(
    parameter int TICK_DIV     = 10000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int MAX_MS       = 9999
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_start,
    input  logic               btn_react,
    output logic [VALUE_W-1:0] value,
    output logic               show_error,
    output logic               stim_led,
    output logic               busy
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [1:0] btn_raw;
    logic [1:0] btn_pulse;
    logic       start_pulse;
    logic       react_pulse;

    assign btn_raw     = {btn_react, btn_start};
    assign start_pulse = btn_pulse[0];
    assign react_pulse = btn_pulse[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            btn_sync_edge u_sync (
                .clk   (clk),
                .reset (reset),
                .btn   (btn_raw[gi]),
                .pulse (btn_pulse[gi])
            );
        end
    endgenerate

    logic [15:0] lfsr_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], ^(lfsr_reg & LFSR_TAPS)};
        end
    end

    state_t             state_reg;
    logic [PRE_W-1:0]   prescaler_reg;
    logic [VALUE_W-1:0] delay_cnt_reg;
    logic [VALUE_W-1:0] rt_reg;
    logic [VALUE_W-1:0] rt_latched_reg;
    logic [VALUE_W-1:0] best_reg;
    logic               best_valid_reg;
    logic               tick;
    logic [VALUE_W-1:0] new_delay;

    assign tick      = (prescaler_reg == PRE_W'(TICK_DIV - 1));
    assign new_delay = VALUE_W'(MIN_DELAY_MS) + VALUE_W'(lfsr_reg[RAND_BITS-1:0]);

    // Every transition clears the prescaler (later assignment wins) so the
    // first tick in a new state lands exactly TICK_DIV cycles after entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            prescaler_reg  <= '0;
            delay_cnt_reg  <= '0;
            rt_reg         <= '0;
            rt_latched_reg <= '0;
            best_reg       <= '0;
            best_valid_reg <= 1'b0;
            value          <= '0;
            show_error     <= 1'b0;
            stim_led       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            prescaler_reg <= tick ? '0 : prescaler_reg + 1'b1;
            case (state_reg)
                IDLE, SHOW, ERR: begin
                    if (state_reg == IDLE) begin
                        value <= best_valid_reg ? best_reg : '0;
                    end
                    if (start_pulse) begin
                        state_reg     <= ARMED;
                        prescaler_reg <= '0;
                        delay_cnt_reg <= new_delay;
                        value         <= '0;
                        show_error    <= 1'b0;
                        stim_led      <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                ARMED: begin
                    if (react_pulse) begin
                        state_reg     <= ERR;
                        prescaler_reg <= '0;
                        show_error    <= 1'b1;
                        busy          <= 1'b0;
                    end else if (tick) begin
                        if (delay_cnt_reg <= VALUE_W'(1)) begin
                            state_reg     <= GO;
                            prescaler_reg <= '0;
                            delay_cnt_reg <= '0;
                            rt_reg        <= '0;
                            stim_led      <= 1'b1;
                        end else begin
                            delay_cnt_reg <= delay_cnt_reg - 1'b1;
                        end
                    end
                end
                GO: begin
                    // React wins over a tick in the same cycle.
                    if (react_pulse) begin
                        state_reg      <= SHOW;
                        prescaler_reg  <= '0;
                        rt_latched_reg <= rt_reg;
                        value          <= rt_reg;
                        stim_led       <= 1'b0;
                        busy           <= 1'b0;
                        if (!best_valid_reg || rt_reg < best_reg) begin
                            best_reg       <= rt_reg;
                            best_valid_reg <= 1'b1;
                        end
                    end else if (tick) begin
                        if (rt_reg >= VALUE_W'(MAX_MS - 1)) begin
                            state_reg     <= ERR;
                            prescaler_reg <= '0;
                            show_error    <= 1'b1;
                            stim_led      <= 1'b0;
                            busy          <= 1'b0;
                        end else begin
                            rt_reg <= rt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    value     <= '0;
                    busy      <= 1'b0;
                    stim_led  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Randomized rounds of the reaction game checked against a ms-level model.
module tb_reaction_game_ctrl;

    localparam int TICK_DIV     = 4;
    localparam int MIN_DELAY_MS = 2;
    localparam int RAND_BITS    = 2;
    localparam int MAX_MS       = 10;
    // Edges from a pin change to the FSM acting on it.
    localparam int BTN_LAT      = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_react = 1'b0;
    logic [13:0] value;
    logic        show_error;
    logic        stim_led;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int model_best = 0;
    bit model_best_valid = 1'b0;
    int last_rt = 0;

    reaction_game_ctrl #(
        .TICK_DIV     (TICK_DIV),
        .MIN_DELAY_MS (MIN_DELAY_MS),
        .RAND_BITS    (RAND_BITS),
        .MAX_MS       (MAX_MS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_start  (btn_start),
        .btn_react  (btn_react),
        .value      (value),
        .show_error (show_error),
        .stim_led   (stim_led),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Caller sits at a negedge; buttons are held for 'hold' cycles.
    task automatic press(input bit s, input bit r, input int hold);
        btn_start = s;
        btn_react = r;
        repeat (hold) @(negedge clk);
        btn_start = 1'b0;
        btn_react = 1'b0;
    endtask

    task automatic wait_stim(output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cycles++;
            if (stim_led === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle_outputs();
        for (int i = 0; i < 30; i++) begin
            if (busy === 1'b0) break;
            @(negedge clk);
        end
    endtask

    task automatic check_best(input string tag);
        checks++;
        if (dut.best_valid_reg !== model_best_valid) begin
            failures++;
            $display("FAIL %s_best_valid got=%0d want=%0d", tag, dut.best_valid_reg, model_best_valid);
        end
        if (model_best_valid) begin
            checks++;
            if (dut.best_reg !== 14'(model_best)) begin
                failures++;
                $display("FAIL %s_best got=%0d want=%0d", tag, dut.best_reg, model_best);
            end
        end
    endtask

    // One full round: start, wait for the lamp, react t ms after it lit.
    task automatic play_round(input int t, input bit with_start, input int react_hold);
        int  cyc;
        bit  ok;
        int  hold;
        int  wait_cyc;
        int  exp_rt;
        int  lo;
        int  hi;
        hold = int'($urandom_range(2, 5));
        press(1'b1, 1'b0, hold);
        wait_stim(cyc, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stim_timeout got=stim_led_low want=stim_led_high");
            return;
        end
        cyc += hold;
        lo = TICK_DIV * MIN_DELAY_MS + BTN_LAT;
        hi = TICK_DIV * (MIN_DELAY_MS + (1 << RAND_BITS) - 1) + BTN_LAT + 2;
        checks++;
        if (cyc < lo || cyc > hi) begin
            failures++;
            $display("FAIL delay_window got=%0d want=%0d..%0d", cyc, lo, hi);
        end
        checks++;
        if (busy !== 1'b1 || value !== 14'd0) begin
            failures++;
            $display("FAIL go_outputs got busy=%0b value=%0d want busy=1 value=0", busy, value);
        end
        // Aim the press mid-way between the t-th and (t+1)-th ms boundary.
        wait_cyc = TICK_DIV * t - 2;
        repeat (wait_cyc) @(negedge clk);
        // Whole ms elapsed before the press registers; a coincident tick is not counted.
        exp_rt = (wait_cyc + BTN_LAT) / TICK_DIV;
        press(with_start, 1'b1, react_hold);
        wait_idle_outputs();
        checks++;
        if (value !== 14'(exp_rt) || show_error !== 1'b0 || stim_led !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL show_value got value=%0d err=%0b led=%0b busy=%0b want value=%0d err=0 led=0 busy=0",
                     value, show_error, stim_led, busy, exp_rt);
        end
        if (!model_best_valid || exp_rt < model_best) begin
            model_best = exp_rt;
            model_best_valid = 1'b1;
        end
        last_rt = exp_rt;
        $display("round rt=%0d value=%0d best=%0d", exp_rt, value, model_best);
        check_best("round");
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dut.lfsr_reg !== 16'hACE1) begin
            failures++;
            $display("FAIL reset_lfsr got=%h want=ace1", dut.lfsr_reg);
        end
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (value !== 14'd0 || show_error !== 1'b0 || stim_led !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got value=%0d err=%0b led=%0b busy=%0b want all 0",
                     value, show_error, stim_led, busy);
        end
        check_best("reset");
        press(1'b0, 1'b1, 3);
        repeat (10) @(negedge clk);
        checks++;
        if (value !== 14'd0 || show_error !== 1'b0 || stim_led !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_react got value=%0d err=%0b led=%0b busy=%0b want all 0",
                     value, show_error, stim_led, busy);
        end
        $display("reset done value=%0d busy=%0b", value, busy);
    endtask

    task automatic test_best_tracking();
        play_round(5, 1'b0, 3);
        play_round(8, 1'b0, 3);
        play_round(3, 1'b0, 3);
        for (int i = 0; i < 3; i++) begin
            play_round(int'($urandom_range(1, MAX_MS - 1)), 1'b0, int'($urandom_range(2, 5)));
        end
    endtask

    task automatic test_false_start();
        press(1'b1, 1'b0, 3);
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b1) break;
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b1 || stim_led !== 1'b0) begin
            failures++;
            $display("FAIL armed_outputs got busy=%0b led=%0b want busy=1 led=0", busy, stim_led);
        end
        press(1'b0, 1'b1, 3);
        wait_idle_outputs();
        checks++;
        if (show_error !== 1'b1 || value !== 14'd0 || stim_led !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL false_start got err=%0b value=%0d led=%0b busy=%0b want err=1 value=0 led=0 busy=0",
                     show_error, value, stim_led, busy);
        end
        check_best("false_start");
        $display("false start err=%0b value=%0d", show_error, value);
        press(1'b1, 1'b0, 3);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || show_error !== 1'b0) begin
            failures++;
            $display("FAIL err_to_armed got busy=%0b err=%0b want busy=1 err=0", busy, show_error);
        end
    endtask

    // Continues from ARMED: never react, expect a timeout after MAX_MS ms of GO.
    task automatic test_timeout();
        int cyc;
        bit ok;
        wait_stim(cyc, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL timeout_stim got=stim_led_low want=stim_led_high");
            return;
        end
        repeat (TICK_DIV * MAX_MS - 2) @(negedge clk);
        checks++;
        if (stim_led !== 1'b1 || show_error !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early got led=%0b err=%0b want led=1 err=0", stim_led, show_error);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (show_error !== 1'b1 || stim_led !== 1'b0 || value !== 14'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout got err=%0b led=%0b value=%0d busy=%0b want err=1 led=0 value=0 busy=0",
                     show_error, stim_led, value, busy);
        end
        check_best("timeout");
        $display("timeout err=%0b led=%0b", show_error, stim_led);
    endtask

    // Start+react together in GO, both held long: one pulse each, SHOW stays.
    task automatic test_simultaneous();
        play_round(int'($urandom_range(2, MAX_MS - 1)), 1'b1, 12);
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || value !== 14'(last_rt)) begin
            failures++;
            $display("FAIL held_start got busy=%0b value=%0d want busy=0 value=%0d", busy, value, last_rt);
        end
    endtask

    task automatic test_reset_mid_go();
        int cyc;
        bit ok;
        press(1'b1, 1'b0, 3);
        wait_stim(cyc, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL mid_go_stim got=stim_led_low want=stim_led_high");
        end
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_best_valid = 1'b0;
        model_best = 0;
        checks++;
        if (value !== 14'd0 || show_error !== 1'b0 || stim_led !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_go_reset got value=%0d err=%0b led=%0b busy=%0b want all 0",
                     value, show_error, stim_led, busy);
        end
        check_best("mid_go_reset");
        reset = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || stim_led !== 1'b0 || value !== 14'd0) begin
            failures++;
            $display("FAIL post_reset_idle got busy=%0b led=%0b value=%0d want 0 0 0", busy, stim_led, value);
        end
        $display("mid-GO reset busy=%0b value=%0d", busy, value);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_best_tracking();
        test_false_start();
        test_timeout();
        test_simultaneous();
        test_reset_mid_go();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reaction_game_ctrl.md
Name: reaction_game_ctrl

Overview:
- Sequencing controller for the reaction-time test.
- Takes the start and react pushbuttons, runs the random-delay / stimulus / measure cycle and measures reaction time in milliseconds.
- Drives the 14-bit value and show_error inputs of the seven-segment display driver, plus the stimulus LED.
- Sits between the board buttons and the display driver in the top level.

Parameters:
- TICK_DIV, 10000, clk cycles per millisecond tick (10 MHz clk); bench uses 4.
- MIN_DELAY_MS, 1000, minimum random wait before the stimulus, in ms; bench uses 2.
- RAND_BITS, 11, number of LFSR bits added to the delay (delay = MIN_DELAY_MS + lfsr[RAND_BITS-1:0]).
- MAX_MS, 9999, reaction-time timeout in ms (display limit).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset (sampled on rising clk)
- btn_start  input  1  start button, debounced, asynchronous to clk
- btn_react  input  1  react button, debounced, asynchronous to clk
- value  output  14  number to display, 0..9999
- show_error  output  1  display "Err"
- stim_led  output  1  stimulus lamp, high while the player should react
- busy  output  1  high in ARMED or GO

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; value=0, show_error=0, stim_led=0, busy=0.
  - best_valid=0, prescaler=0, lfsr=16'hACE1.
  - Reset mid-round aborts the round with no residue.
- Input conditioning:
  - Each button passes through a 2-flop synchronizer, then a rising-edge detector that produces a one-cycle pulse.
  - A pin rising before edge N gives a pulse seen by the FSM at edge N+2; the FSM acts at edge N+3.
  - A held button produces exactly one pulse.
- LFSR:
  - 16-bit Fibonacci, taps 16/14/13/11, shifts every cycle (including in IDLE).
  - Never reaches zero.
  - Sampled only on entry to ARMED.
- ms tick:
  - Prescaler counts 0..TICK_DIV-1; tick=1 in the cycle it equals TICK_DIV-1, then it wraps to 0.
  - Prescaler is forced to 0 on every state transition, so the first tick after entry is exactly TICK_DIV cycles later.
- FSM states: IDLE, ARMED, GO, SHOW, ERR.
  - IDLE:
    - Outputs: value=best_valid?best:0.
    - start -> ARMED, loading delay_cnt = MIN_DELAY_MS + lfsr[RAND_BITS-1:0].
    - react ignored.
  - ARMED:
    - Outputs: busy=1, value=0.
    - react -> ERR (false start).
    - Else on tick: delay_cnt decrements. The tick that takes delay_cnt from 1 to 0 moves to GO with rt=0.
    - start ignored.
  - GO:
    - Outputs: stim_led=1, busy=1, value=0.
    - react -> SHOW, latching rt as it stands before any same-cycle tick (react wins over tick).
    - Else on tick: rt++. When rt would reach MAX_MS -> ERR (timeout).
    - start ignored.
  - SHOW:
    - Outputs: value=rt_latched.
    - start -> ARMED (new delay sampled). react ignored.
  - ERR:
    - Outputs: show_error=1, value=0.
    - start -> ARMED. react ignored.
- Simultaneous start and react:
  - ARMED/GO: react takes priority.
  - IDLE/SHOW/ERR: start takes priority.
- Best-time update:
  - On GO->SHOW, if !best_valid or rt<best: best=rt, best_valid=1.
  - ERR never updates best.
  - best persists across rounds and is cleared only by reset.
- Output timing and widths:
  - All outputs are registered and reflect the new state one cycle after the transition edge.
  - rt, best and delay_cnt are 14 bits; rt never exceeds MAX_MS.

Decomposition:
- Shared package reaction_pkg holds:
  - the state enum (IDLE, ARMED, GO, SHOW, ERR);
  - LFSR_SEED=16'hACE1 and the tap constant;
  - VALUE_W=14.
- One sub-module is natural: btn_sync_edge (2-flop sync + rising-edge pulse, clk/reset), instantiated twice.
- Prescaler, LFSR and FSM stay in the top module.

Test Plan (TICK_DIV=4, MIN_DELAY_MS=2, RAND_BITS=2):
- Reset, then idle 20 cycles -> value=0, show_error=0, stim_led=0, busy=0. Press react -> outputs unchanged.
- Start pulse, wait for stim_led rise, press react after 5 ticks -> SHOW with value=5, best=5.
- Second round with react after 8 ticks -> value=8 in SHOW. Return via reset-free IDLE check is not possible, so compare best via an internal probe: best stays 5. A third round at 3 ticks -> best=3.
- Start, press react while busy=1 and stim_led=0 -> ERR: show_error=1, value=0, best unchanged. Start from ERR -> ARMED.
- MAX_MS=10: start, never react -> after 10 ticks in GO, ERR with show_error=1 and stim_led=0.
- Edge cases:
  - start and react asserted in the same cycle while in GO -> SHOW with the current rt.
  - Assert reset low mid-GO -> next cycle IDLE, all outputs 0, best_valid=0.
